flit_link_rx: RTL and testbench
===============================

Name: flit_link_rx

Overview:
- Downstream link receiver that attaches to a switch output port, i.e. the consumer of the switch's out / data_ready_out pair.
- Accepts flits into per-VC circular FIFOs and acknowledges each accepted flit with packet_sent.
- Returns one credit per VC slot freed, on the lines that feed the switch's credit_granted input.
- Drains buffered flits to a local consumer over a valid/ready interface, with round-robin arbitration across VCs.

Parameters:
- NUM_VCS, 2, number of virtual channels; FIFOs and credit lines are per VC.
- DEPTH, 8, flits per VC FIFO; power of two, at least 2. Must equal the BUFFER_SIZE the upstream switch assumes.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_flit  input  chiplet_types_pkg::flit_t  flit from the switch out port; VC taken from in_flit.vc.
- data_ready_in  input  1  in_flit valid this cycle.
- packet_sent  output  1  one-cycle pulse acknowledging an accepted flit.
- credit_granted  output  NUM_VCS  per-VC one-cycle credit-return pulse.
- out_flit  output  chiplet_types_pkg::flit_t  head flit of the selected VC.
- out_vc  output  $clog2(NUM_VCS)  VC of out_flit.
- out_valid  output  1  out_flit valid.
- out_ready  input  1  consumer accepts out_flit.
- overflow  output  1  sticky: a flit arrived for a full VC.

Behaviour:
- Reset: all FIFOs empty, pointers 0, round-robin pointer 0. packet_sent=0, credit_granted=0, out_valid=0, out_flit=0, out_vc=0, overflow=0. Reset mid-operation discards buffered flits; pulses scheduled for the next cycle are suppressed.
- Credit state: the upstream switch holds DEPTH credits per VC after reset. The block never pulses credits at reset.
- Push: when data_ready_in=1, v=in_flit.vc.
  - The flit is written when count[v]<DEPTH, or when count[v]==DEPTH and VC v pops in the same cycle. In the second case count is unchanged and the write slot is the freed head slot after pointer advance.
  - packet_sent is registered: it pulses in the cycle after the write.
- Drop: a flit for a full VC with no same-cycle pop is dropped. overflow sets and holds until rst. No packet_sent is generated.
- Out-of-range VC: in_flit.vc >= NUM_VCS is treated as a drop and sets overflow.
- Pointers: wrap modulo DEPTH. count width is $clog2(DEPTH)+1.
- Drain FSM, 2 states:
  - IDLE: out_valid=0. If any VC is non-empty, pick the first non-empty VC at or after rr_ptr, cyclically. Latch it into sel_vc and go to PRESENT in the next cycle.
  - PRESENT: out_valid=1, out_vc=sel_vc, out_flit=head of sel_vc. sel_vc and out_flit are held stable until out_ready=1.
  - On handshake: pop sel_vc and set rr_ptr=sel_vc+1 mod NUM_VCS.
    - If any VC is still non-empty after the pop (counting a same-cycle push), select the next VC the same way and stay in PRESENT, giving back-to-back throughput of 1 flit/cycle.
    - Otherwise go to IDLE.
- Empty-to-output latency: a flit written in cycle N appears with out_valid=1 in cycle N+2 from IDLE.
- Credit return: a pop of VC v pulses credit_granted[v] in the cycle after the handshake. At most one credit bit is set per cycle.
- Simultaneous push and pop on different VCs are independent. Push and pop on the same non-full VC leave count unchanged.
- Read data must not depend combinationally on in_flit; no bypass.

Optional Feature:
- Macro FLIT_LINK_RX_STATS_EN.
- When defined, two extra outputs are present:
  - accepted_count, 16 bits: increments on every written flit.
  - dropped_count, 16 bits: increments on every drop.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset then idle: after rst, all outputs are 0 for 10 cycles; no credit pulses.
- Single flit on VC1 (data_ready_in=1 at cycle N, out_ready=1):
  - packet_sent=1 at N+1.
  - out_valid=1, out_vc=1, same flit at N+2.
  - credit_granted=2'b10 at N+3.
- Fill VC0 with 8 flits while out_ready=0, then send a 9th flit to VC0:
  - 8 packet_sent pulses; 9th dropped; overflow=1.
  - Release out_ready: 8 flits out in order, 8 credit_granted[0] pulses.
- Fairness: 4 flits each to VC0 and VC1 with out_ready held at 1 → output VC order 0,1,0,1,0,1,0,1 and 1 flit/cycle after the first.
- Stall stability: out_ready=0 for 5 cycles while a flit is presented → out_flit and out_vc are unchanged each cycle; no credit pulse.
- Full plus same-cycle pop on VC0 with count=8, out_valid on VC0, out_ready=1 and data_ready_in=1 → flit accepted, no overflow, count stays 8, credit_granted[0] pulses once.

Source files
------------

// File: rtl/flit_link_rx.sv
// flit_link_rx: downstream link receiver sitting on a switch output port.
//
// Accepts flits into per-VC circular FIFOs, acknowledges every written flit
// with a registered packet_sent pulse, returns one credit per freed slot on
// credit_granted, and drains buffered flits to a local consumer over a
// valid/ready interface with round-robin arbitration across VCs.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_flit         incoming flit (VC taken from in_flit.vc)
//   data_ready_in   in_flit valid this cycle
//   packet_sent     one-cycle pulse, cycle after a flit is written
//   credit_granted  per-VC one-cycle credit pulse, cycle after a pop
//   out_flit        head flit of the selected VC (0 when not valid)
//   out_vc          VC of out_flit (0 when not valid)
//   out_valid       out_flit valid
//   out_ready       consumer accepts out_flit
//   overflow        sticky: a flit was dropped (full VC or bad VC index)
//
// Optional build macro FLIT_LINK_RX_STATS_EN adds saturating 16-bit
// accepted_count / dropped_count outputs.

package chiplet_types_pkg;

  typedef struct packed {
    logic [1:0]  vc;
    logic        head;
    logic        tail;
    logic [27:0] payload;
  } flit_t;

endpackage

module flit_link_rx #(
  parameter int unsigned NUM_VCS = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  chiplet_types_pkg::flit_t   in_flit,
  input  logic                       data_ready_in,
  output logic                       packet_sent,
  output logic [NUM_VCS-1:0]         credit_granted,
  output chiplet_types_pkg::flit_t   out_flit,
  output logic [$clog2(NUM_VCS)-1:0] out_vc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow
`ifdef FLIT_LINK_RX_STATS_EN
  ,
  output logic [15:0]                accepted_count,
  output logic [15:0]                dropped_count
`endif
);

  import chiplet_types_pkg::*;

  localparam int unsigned VcW  = $clog2(NUM_VCS);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StPresent} state_e;

  state_e          state_q, state_d;
  logic [VcW-1:0]  sel_q, sel_d;
  logic [VcW-1:0]  rr_q, rr_d;
  logic [VcW-1:0]  rr_inc;

  flit_t           mem_q    [NUM_VCS][DEPTH];
  logic [PtrW-1:0] wr_ptr_q [NUM_VCS];
  logic [PtrW-1:0] rd_ptr_q [NUM_VCS];
  logic [CntW-1:0] cnt_q    [NUM_VCS];
  logic [CntW-1:0] cnt_d    [NUM_VCS];

  logic [NUM_VCS-1:0] push_v, pop_v;
  logic [NUM_VCS-1:0] ne_now, ne_next;
  logic [VcW-1:0]     push_idx;
  logic               vc_in_range;
  logic               push_full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [VcW:0]       pick_idle, pick_next;

  // Round-robin search: first set bit of ne at or after start, cyclically.
  // Result is {found, index}.
  function automatic logic [VcW:0] rr_pick(input logic [VcW-1:0]     start,
                                           input logic [NUM_VCS-1:0] ne);
    logic [VcW:0] r;
    int           idx;
    r = '0;
    // Walk downwards so the closest candidate to start wins.
    for (int i = int'(NUM_VCS) - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= int'(NUM_VCS)) idx = idx - int'(NUM_VCS);
      if (ne[idx]) r = {1'b1, VcW'(idx)};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Push / pop decode
  // ---------------------------------------------------------------------------
  always_comb begin
    push_idx    = in_flit.vc[VcW-1:0];
    vc_in_range = int'(in_flit.vc) < int'(NUM_VCS);
    pop         = (state_q == StPresent) && out_ready;
    push_full   = vc_in_range && (cnt_q[push_idx] == CntW'(DEPTH));
    // A full VC still accepts when its head leaves in the same cycle; the
    // write lands in the slot being freed (wr_ptr == rd_ptr when full).
    push_ok     = data_ready_in && vc_in_range &&
                  (!push_full || (pop && (sel_q == push_idx)));
    drop        = data_ready_in && !push_ok;
  end

  always_comb begin
    for (int v = 0; v < int'(NUM_VCS); v++) begin
      push_v[v] = push_ok && (push_idx == VcW'(v));
      pop_v[v]  = pop && (sel_q == VcW'(v));
      cnt_d[v]  = cnt_q[v];
      if (push_v[v] && !pop_v[v]) begin
        cnt_d[v] = cnt_q[v] + CntW'(1);
      end else if (pop_v[v] && !push_v[v]) begin
        cnt_d[v] = cnt_q[v] - CntW'(1);
      end
      ne_now[v]  = (cnt_q[v] != '0);
      ne_next[v] = (cnt_d[v] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_inc    = (sel_q == VcW'(NUM_VCS - 1)) ? '0 : sel_q + VcW'(1);
    pick_idle = rr_pick(rr_q, ne_now);
    pick_next = rr_pick(rr_inc, ne_next);

    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;

    unique case (state_q)
      StIdle: begin
        if (pick_idle[VcW]) begin
          sel_d   = pick_idle[VcW-1:0];
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (out_ready) begin
          rr_d = rr_inc;
          // Post-pop occupancy includes a same-cycle push, so a VC refilled
          // this cycle keeps the stream going without a bubble.
          if (pick_next[VcW]) begin
            sel_d = pick_next[VcW-1:0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sel_q          <= '0;
      rr_q           <= '0;
      packet_sent    <= 1'b0;
      credit_granted <= '0;
      overflow       <= 1'b0;
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        cnt_q[v]    <= '0;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      rr_q           <= rr_d;
      packet_sent    <= push_ok;
      credit_granted <= pop_v;
      overflow       <= overflow | drop;
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        cnt_q[v] <= cnt_d[v];
        if (push_v[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PtrW'(1);
        if (pop_v[v])  rd_ptr_q[v] <= rd_ptr_q[v] + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[push_idx][wr_ptr_q[push_idx]] <= in_flit;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: read data comes from stored state only, never from in_flit.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (state_q == StPresent);
    out_vc    = '0;
    out_flit  = '0;
    if (out_valid) begin
      out_vc   = sel_q;
      out_flit = mem_q[sel_q][rd_ptr_q[sel_q]];
    end
  end

`ifdef FLIT_LINK_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (push_ok && (accepted_count != 16'hFFFF)) begin
        accepted_count <= accepted_count + 16'd1;
      end
      if (drop && (dropped_count != 16'hFFFF)) begin
        dropped_count <= dropped_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_flit_link_rx.sv
// Directed self-checking bench for flit_link_rx (NUM_VCS=2, DEPTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_flit_link_rx;
  import chiplet_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  flit_t       in_flit;
  logic        data_ready_in;
  logic        packet_sent;
  logic [1:0]  credit_granted;
  flit_t       out_flit;
  logic        out_vc;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
`ifdef FLIT_LINK_RX_STATS_EN
  logic [15:0] accepted_count;
  logic [15:0] dropped_count;
`endif

  int checks   = 0;
  int failures = 0;

  flit_link_rx #(
    .NUM_VCS(2),
    .DEPTH  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_flit       (in_flit),
    .data_ready_in (data_ready_in),
    .packet_sent   (packet_sent),
    .credit_granted(credit_granted),
    .out_flit      (out_flit),
    .out_vc        (out_vc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow)
`ifdef FLIT_LINK_RX_STATS_EN
    ,
    .accepted_count(accepted_count),
    .dropped_count (dropped_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mk(input logic [1:0] vc, input logic [27:0] p);
    flit_t f;
    f.vc      = vc;
    f.head    = 1'b1;
    f.tail    = 1'b1;
    f.payload = p;
    return f;
  endfunction

  initial begin
    rst           = 1'b1;
    data_ready_in = 1'b0;
    out_ready     = 1'b0;
    in_flit       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset then idle: every output stays zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 64'({packet_sent, credit_granted, out_valid, out_vc, overflow,
                               out_flit}), 64'd0);
    end

    // Single flit on VC1.
    out_ready     = 1'b1;
    in_flit       = mk(2'd1, 28'h0A1);
    data_ready_in = 1'b1;
    @(negedge clk);
    data_ready_in = 1'b0;
    in_flit       = '0;
    chk("single_ack", 64'(packet_sent), 64'd1);
    chk("single_not_yet_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_vc", 64'(out_vc), 64'd1);
    chk("single_flit", 64'(out_flit), 64'(mk(2'd1, 28'h0A1)));
    chk("single_no_early_credit", 64'(credit_granted), 64'd0);
    @(negedge clk);
    chk("single_credit", 64'(credit_granted), 64'b10);
    chk("single_idle_after", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("single_credit_cleared", 64'(credit_granted), 64'd0);

    // Fill VC0 with 8 flits while the consumer stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_flit       = mk(2'd0, 28'h100 + 28'(i));
      data_ready_in = 1'b1;
      @(negedge clk);
      chk("fill_ack", 64'(packet_sent), 64'd1);
    end
    data_ready_in = 1'b0;
    in_flit       = '0;

    // Stall stability on the presented head.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_vc", 64'(out_vc), 64'd0);
      chk("stall_flit", 64'(out_flit), 64'(mk(2'd0, 28'h100)));
      chk("stall_no_credit", 64'(credit_granted), 64'd0);
    end

    // Full VC0 plus same-cycle pop: the push is accepted.
    out_ready     = 1'b1;
    in_flit       = mk(2'd0, 28'h108);
    data_ready_in = 1'b1;
    @(negedge clk);
    out_ready     = 1'b0;
    data_ready_in = 1'b0;
    chk("fullpop_ack", 64'(packet_sent), 64'd1);
    chk("fullpop_credit", 64'(credit_granted), 64'b01);
    chk("fullpop_no_overflow", 64'(overflow), 64'd0);
    chk("fullpop_still_valid", 64'(out_valid), 64'd1);
    chk("fullpop_next_head", 64'(out_flit), 64'(mk(2'd0, 28'h101)));

    // VC0 is full again (count 8): this flit must be dropped.
    in_flit       = mk(2'd0, 28'h1FF);
    data_ready_in = 1'b1;
    @(negedge clk);
    data_ready_in = 1'b0;
    in_flit       = '0;
    chk("drop_no_ack", 64'(packet_sent), 64'd0);
    chk("drop_overflow", 64'(overflow), 64'd1);
    chk("drop_no_credit", 64'(credit_granted), 64'd0);

    // Release the consumer: 8 flits in order, one credit per pop.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_vc", 64'(out_vc), 64'd0);
      chk("drain_flit", 64'(out_flit), 64'(mk(2'd0, 28'h101 + 28'(i))));
      chk("drain_credit", 64'(credit_granted), (i == 0) ? 64'd0 : 64'b01);
      @(negedge clk);
    end
    chk("drain_last_credit", 64'(credit_granted), 64'b01);
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_overflow_sticky", 64'(overflow), 64'd1);
    @(negedge clk);
    chk("drain_credit_cleared", 64'(credit_granted), 64'd0);

    // Reset mid-operation discards buffered data and a same-cycle push.
    out_ready     = 1'b0;
    in_flit       = mk(2'd1, 28'h2AA);
    data_ready_in = 1'b1;
    @(negedge clk);
    data_ready_in = 1'b0;
    chk("mid_ack", 64'(packet_sent), 64'd1);
    @(negedge clk);
    chk("mid_valid", 64'(out_valid), 64'd1);
    rst           = 1'b1;
    in_flit       = mk(2'd1, 28'h2BB);
    data_ready_in = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    data_ready_in = 1'b0;
    chk("rst_no_ack", 64'(packet_sent), 64'd0);
    chk("rst_overflow_clear", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_discard", 64'({out_valid, packet_sent, credit_granted}), 64'd0);
    end

    // Out-of-range VC index is a drop.
    in_flit       = mk(2'd2, 28'h003);
    data_ready_in = 1'b1;
    @(negedge clk);
    data_ready_in = 1'b0;
    chk("badvc_no_ack", 64'(packet_sent), 64'd0);
    chk("badvc_overflow", 64'(overflow), 64'd1);
    repeat (2) @(negedge clk);
    chk("badvc_nothing_out", 64'(out_valid), 64'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_overflow_clear2", 64'(overflow), 64'd0);

    // Fairness: 4 flits per VC buffered, then streamed back to back.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_flit       = mk({1'b0, i[0]}, 28'h400 + 28'(i));
      data_ready_in = 1'b1;
      @(negedge clk);
    end
    data_ready_in = 1'b0;
    in_flit       = '0;
    out_ready     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_vc", 64'(out_vc), 64'(k % 2));
      chk("rr_flit", 64'(out_flit), 64'(mk({1'b0, k[0]}, 28'h400 + 28'(k))));
      @(negedge clk);
    end
    chk("rr_done", 64'(out_valid), 64'd0);
    chk("rr_last_credit", 64'(credit_granted), 64'b10);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
